// File: rtl/simd_accumulate_block.sv
// SIMD block accumulator: sums ACC_LEN beats of a+b per lane, with per-field wrap
// (32/16/8-bit) or a cross-lane reduction, then holds the result until it is taken.
module simd_accumulate_block #(
    parameter int NUM_LANES = 2,
    parameter int LANE_W    = 32,
    parameter int ACC_LEN   = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic [1:0]                       mode_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [NUM_LANES*LANE_W-1:0]      p_a_i,
    input  logic [NUM_LANES*LANE_W-1:0]      p_b_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [NUM_LANES*LANE_W-1:0]      sums_o,
    output logic [$clog2(ACC_LEN+1)-1:0]     count_o
);

    localparam int CW = $clog2(ACC_LEN + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(ACC_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t              state;
    state_t              state_next;
    logic [LANE_W-1:0]   acc [NUM_LANES];
    logic [CW-1:0]       count;
    logic [1:0]          mode_q;
    logic [1:0]          mode_acc;
    logic                accept;
    logic [LANE_W-1:0]   total;

    // Partitioned add: carries never cross a field boundary, each field wraps.
    function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] acc_v,
                                                   input logic [LANE_W-1:0] a_v,
                                                   input logic [LANE_W-1:0] b_v,
                                                   input logic [1:0]        mode_v);
        logic [LANE_W-1:0] r;
        r = '0;
        case (mode_v)
            2'd1: begin
                for (int f = 0; f < LANE_W / 16; f++)
                    r[f*16 +: 16] = acc_v[f*16 +: 16] + a_v[f*16 +: 16] + b_v[f*16 +: 16];
            end
            2'd2: begin
                for (int f = 0; f < LANE_W / 8; f++)
                    r[f*8 +: 8] = acc_v[f*8 +: 8] + a_v[f*8 +: 8] + b_v[f*8 +: 8];
            end
            default: r = acc_v + a_v + b_v;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = (ACC_LEN == 1) ? DONE : ACCUM;
                ACCUM:   if (accept && count == LAST_BEAT) state_next = DONE;
                DONE:    if (ready_i) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = (state != DONE);
        valid_o = (state == DONE);
    end

    assign accept   = valid_i & ready_o & ~clear_i;
    // The first beat of a block uses the live mode; later beats use the latched one.
    assign mode_acc = (state == IDLE) ? mode_i : mode_q;
    assign count_o  = count;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_LANES; k++) acc[k] <= '0;
            count  <= '0;
            mode_q <= 2'd0;
        end else if (clear_i || (valid_o && ready_i)) begin
            for (int k = 0; k < NUM_LANES; k++) acc[k] <= '0;
            count <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_LANES; k++)
                acc[k] <= lane_add(acc[k], p_a_i[k*LANE_W +: LANE_W],
                                   p_b_i[k*LANE_W +: LANE_W], mode_acc);
            count <= count + CW'(1);
            if (state == IDLE) mode_q <= mode_i;
        end
    end

    always_comb begin
        total  = '0;
        sums_o = '0;
        for (int k = 0; k < NUM_LANES; k++) total = total + acc[k];
        if (valid_o) begin
            if (mode_q == 2'd3) begin
                sums_o[LANE_W-1:0] = total;
            end else begin
                for (int k = 0; k < NUM_LANES; k++) sums_o[k*LANE_W +: LANE_W] = acc[k];
            end
        end
    end

endmodule

// File: tb/tb_simd_accumulate_block.sv
// Bench for simd_accumulate_block: directed vector table, corner sequences and
// randomized blocks checked against a field-arithmetic reference model.
module tb_simd_accumulate_block;

    localparam int NL = 2;
    localparam int LW = 32;
    localparam int AL = 4;
    localparam int W  = NL * LW;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic [1:0]    mode_i = 2'd0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [W-1:0]  p_a_i = '0;
    logic [W-1:0]  p_b_i = '0;
    logic          ready_o, valid_o;
    logic [W-1:0]  sums_o;
    logic [2:0]    count_o;

    logic          ready1, valid1;
    logic [LW-1:0] sums1;
    logic [0:0]    count1;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    simd_accumulate_block #(.NUM_LANES(NL), .LANE_W(LW), .ACC_LEN(AL)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .mode_i(mode_i),
        .valid_i(valid_i), .ready_o(ready_o), .p_a_i(p_a_i), .p_b_i(p_b_i),
        .valid_o(valid_o), .ready_i(ready_i), .sums_o(sums_o), .count_o(count_o)
    );

    simd_accumulate_block #(.NUM_LANES(1), .LANE_W(LW), .ACC_LEN(1)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .mode_i(mode_i),
        .valid_i(valid_i), .ready_o(ready1), .p_a_i(p_a_i[LW-1:0]), .p_b_i(p_b_i[LW-1:0]),
        .valid_o(valid1), .ready_i(ready_i), .sums_o(sums1), .count_o(count1)
    );

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sums;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: each field independently sums (a+b) over all beats, mod 2^field-width.
    function automatic logic [W-1:0] model(input logic [1:0] m,
                                           input logic [W-1:0] a [AL],
                                           input logic [W-1:0] b [AL]);
        logic [W-1:0]   r;
        longint unsigned s, fmask;
        int fw;
        r = '0;
        if (m == 2'd3) begin
            s = 0;
            for (int t = 0; t < AL; t++)
                for (int l = 0; l < NL; l++)
                    s += longint'(a[t][l*LW +: LW]) + longint'(b[t][l*LW +: LW]);
            r[LW-1:0] = s[LW-1:0];
        end else begin
            fw = (m == 2'd1) ? 16 : (m == 2'd2) ? 8 : 32;
            fmask = (64'd1 << fw) - 1;
            for (int l = 0; l < NL; l++) begin
                for (int f = 0; f < LW / fw; f++) begin
                    s = 0;
                    for (int t = 0; t < AL; t++)
                        s += ((longint'(a[t]) >> (l*LW + f*fw)) & fmask)
                           + ((longint'(b[t]) >> (l*LW + f*fw)) & fmask);
                    r = r | (W'(s & fmask) << (l*LW + f*fw));
                end
            end
        end
        return r;
    endfunction

    task automatic beat(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        valid_i = 1'b1; mode_i = m; p_a_i = a; p_b_i = b;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic take_result();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    logic [W-1:0] a_q [AL];
    logic [W-1:0] b_q [AL];
    logic [W-1:0] exp_s;
    logic [1:0]   m;

    initial begin
        vecs[0] = '{2'd0, {2{32'h01010101}}, {2{32'h7F7F7F7F}}, {2{32'h02020200}}};
        vecs[1] = '{2'd2, {2{32'h01010101}}, {2{32'h7F7F7F7F}}, {2{32'h00000000}}};
        vecs[2] = '{2'd1, {2{32'h01010101}}, {2{32'h7F7F7F7F}}, {2{32'h02000200}}};
        vecs[3] = '{2'd3, {32'h8, 32'h4},    64'h0,              {32'h0, 32'h30}};
        vecs[4] = '{2'd0, {2{32'h00000001}}, 64'h0,              {2{32'h00000004}}};

        // Reset state
        tick(); tick();
        rst_ni = 1'b1;
        check("rst_ready", W'(ready_o), W'(1));
        check("rst_valid", W'(valid_o), W'(0));
        check("rst_sums", sums_o, '0);
        check("rst_count", W'(count_o), W'(0));

        // ACC_LEN=1 instance goes straight to DONE after one beat
        beat(2'd0, {32'h0, 32'h11223344}, {32'h0, 32'h01010101});
        check("al1_valid", W'(valid1), W'(1));
        check("al1_ready", W'(ready1), W'(0));
        check("al1_sums", W'(sums1), W'(32'h12233445));
        check("al1_count", W'(count1), W'(1));
        check("al1_main_count", W'(count_o), W'(1));
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        check("al1_clear_valid", W'(valid1), W'(0));

        // Directed vector table; mode_i toggles after the first beat and must be ignored
        for (int v = 0; v < 5; v++) begin
            for (int t = 0; t < AL; t++) begin
                beat((t == 0) ? vecs[v].mode : (vecs[v].mode ^ 2'b01), vecs[v].a, vecs[v].b);
                if (t == AL - 2) check($sformatf("vec%0d_notdone", v), W'(valid_o), W'(0));
            end
            check($sformatf("vec%0d_valid", v), W'(valid_o), W'(1));
            check($sformatf("vec%0d_ready", v), W'(ready_o), W'(0));
            check($sformatf("vec%0d_count", v), W'(count_o), W'(AL));
            check($sformatf("vec%0d_sums", v), sums_o, vecs[v].sums);
            take_result();
            check($sformatf("vec%0d_idle_sums", v), sums_o, '0);
            check($sformatf("vec%0d_idle_count", v), W'(count_o), W'(0));
        end

        // 16-bit field overflow must not carry into the upper half
        beat(2'd1, {32'h0, 32'h0000FFFF}, {32'h0, 32'h00000001});
        for (int t = 1; t < AL; t++) beat(2'd1, '0, '0);
        check("m1_wrap_sums", sums_o, '0);
        take_result();

        // Back-pressure in DONE with valid_i asserted
        for (int t = 0; t < AL; t++) beat(2'd0, {2{32'h1}}, '0);
        valid_i = 1'b1; p_a_i = {2{32'hDEADBEEF}};
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_valid", W'(valid_o), W'(1));
            check("bp_sums", sums_o, {2{32'h4}});
            check("bp_count", W'(count_o), W'(AL));
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0; valid_i = 1'b0;
        check("bp_release_valid", W'(valid_o), W'(0));
        check("bp_release_count", W'(count_o), W'(0));
        check("bp_release_ready", W'(ready_o), W'(1));

        // Clear mid-block drops the beat presented with it
        beat(2'd0, {2{32'h5}}, '0);
        beat(2'd0, {2{32'h5}}, '0);
        clear_i = 1'b1; valid_i = 1'b1;
        tick();
        clear_i = 1'b0; valid_i = 1'b0;
        check("clr_count", W'(count_o), W'(0));
        check("clr_valid", W'(valid_o), W'(0));
        for (int t = 0; t < AL; t++) beat(2'd0, {2{32'h1}}, '0);
        check("clr_block_sums", sums_o, {2{32'h4}});

        // Clear wins over the output handshake, then reset in DONE
        clear_i = 1'b1; ready_i = 1'b1;
        tick();
        clear_i = 1'b0; ready_i = 1'b0;
        check("clr_done_valid", W'(valid_o), W'(0));
        for (int t = 0; t < AL; t++) beat(2'd2, {2{32'h3}}, '0);
        check("rst_done_pre", W'(valid_o), W'(1));
        rst_ni = 1'b0; clear_i = 1'b1;
        tick();
        rst_ni = 1'b1; clear_i = 1'b0;
        check("rst_done_valid", W'(valid_o), W'(0));
        check("rst_done_sums", sums_o, '0);
        check("rst_done_count", W'(count_o), W'(0));

        // Randomized blocks with idle gaps and ignored mode changes
        for (int blk = 0; blk < 40; blk++) begin
            m = 2'($urandom_range(0, 3));
            for (int t = 0; t < AL; t++) begin
                repeat ($urandom_range(0, 2)) begin
                    valid_i = 1'b0; p_a_i = {$urandom, $urandom}; mode_i = 2'($urandom_range(0, 3));
                    tick();
                end
                a_q[t] = {$urandom, $urandom};
                b_q[t] = {$urandom, $urandom};
                beat((t == 0) ? m : 2'($urandom_range(0, 3)), a_q[t], b_q[t]);
            end
            exp_s = model(m, a_q, b_q);
            check("rnd_valid", W'(valid_o), W'(1));
            check("rnd_count", W'(count_o), W'(AL));
            check("rnd_sums", sums_o, exp_s);
            repeat ($urandom_range(0, 3)) begin
                valid_i = 1'($urandom); p_a_i = {$urandom, $urandom};
                tick();
                check("rnd_hold_sums", sums_o, exp_s);
            end
            valid_i = 1'b0;
            take_result();
            check("rnd_idle", W'(valid_o), W'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
